mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single 8-bit program/data memory between two requesters: the processor core (fetch and operand/out accesses sequenced by the control unit) and a loader/debug port that preloads programs or inspects memory.
- Sits between both requesters and the memory macro.
- Grants one access at a time, sequences the fixed-latency memory transaction, and returns a one-cycle acknowledge to the owner.
- A starvation counter prevents the processor's back-to-back fetches from locking the loader out.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_LAT, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid (>=1).
- STARVE_MAX, 3, consecutive lost arbitrations after which the loader gets priority (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- clr  in  1  asynchronous active-low reset.
- cpu_req  in  1  core access request, held until cpu_ack.
- cpu_rw  in  1  1=write, 0=read.
- cpu_addr  in  AW  core address.
- cpu_wdata  in  DW  core write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data, valid from cpu_ack until the next cpu_ack.
- ldr_req  in  1  loader request, held until ldr_ack.
- ldr_rw  in  1  1=write, 0=read.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_ack  out  1  one-cycle completion pulse.
- ldr_rdata  out  DW  read data, valid from ldr_ack until the next ldr_ack.
- mem_en  out  1  memory strobe, exactly one cycle per access.
- mem_rw  out  1  1=write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- arb_busy  out  1  high from ISSUE through ACK.
- arb_owner  out  1  0=core, 1=loader; valid while arb_busy.

Behaviour:
- Reset:
  - Single clock clk; clr asynchronous active-low.
  - While clr=0, all outputs are 0, the FSM is in IDLE, and the starvation counter is 0.
  - Reset mid-access aborts it: no ack is issued, and requests still pending after release are serviced from scratch.
- All outputs are registered.
- FSM IDLE->ISSUE->WAIT->ACK->IDLE.
- IDLE:
  - If any request is present, choose the owner, latch rw/addr/wdata from the owner into the mem_* registers, and go to ISSUE.
  - With no requests, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1.
  - Load the latency counter with MEM_LAT.
- WAIT:
  - Decrement each cycle.
  - In the cycle the count reaches 1, capture mem_rdata into the owner's rdata register on reads. Writes leave rdata unchanged.
  - Then go to ACK.
- ACK (1 cycle):
  - Owner's ack=1.
  - Then go to IDLE.
  - Requests are ignored in ACK; a requester sees ack and drops or renews its request by the following edge.
- Latency:
  - A request first seen in IDLE at cycle T0 gives mem_en in T1, rdata sampled in T1+MEM_LAT, and ack in T1+MEM_LAT+1 (MEM_LAT+2 cycles).
  - Minimum access spacing is MEM_LAT+3 cycles.
- mem_addr/mem_rw/mem_wdata hold their values from ISSUE until the next grant. mem_en is 0 outside ISSUE.
- Arbitration happens in IDLE only:
  - Only one requesting: that requester wins.
  - Both requesting: the core wins unless starve_cnt==STARVE_MAX, in which case the loader wins.
- starve_cnt:
  - Increments when the loader requests and loses (saturates at STARVE_MAX).
  - Clears when the loader is granted.
  - Holds otherwise.
- Request inputs may change at any time; only values present at the IDLE decision edge are used.
- cpu_ack and ldr_ack are never high in the same cycle.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Adds outputs stat_cpu_cnt (16) and stat_ldr_cnt (16).
  - Each counts completed acks for its port, saturating at 16'hFFFF.
  - Both clear on clr=0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Core read: MEM_LAT=1, mem[0x12]=0x5A; cpu_req rw=0 addr=0x12 at T0 -> mem_en/addr=0x12 in T1, cpu_ack in T3 with cpu_rdata=0x5A, arb_owner=0.
- Write then read: loader write 0x34 to 0x80, then core read 0x80 -> ldr_ack 3 cycles after its request, then cpu_rdata=0x34; ldr_rdata unchanged by the write.
- Starvation (STARVE_MAX=3): cpu_req and ldr_req held high continuously -> grant order core, core, core, loader, core...; ldr_ack on the 4th completed access.
- Latency (MEM_LAT=3): core read at T0 -> mem_en in T1 only, data sampled in T4, cpu_ack in T5; arb_busy high T1..T5.
- Reset mid-access: clr low during WAIT -> all outputs 0 at once, no ack; after release with cpu_req still high -> fresh ISSUE at T1 after the first IDLE cycle, and correct ack.
- ARB_STATS_EN: 5 core and 2 loader accesses -> stat_cpu_cnt=5, stat_ldr_cnt=2; clr -> both 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (core / loader) in front of a single fixed-latency 8-bit memory; ARB_STATS_EN adds per-port ack counters.
// Latency: request seen in IDLE at T0 -> mem_en T1, rdata sampled T1+MEM_LAT, ack T1+MEM_LAT+1; accesses spaced MEM_LAT+3.
// Backpressure: req/ack handshake, requests held until ack; loader wins after STARVE_MAX consecutive lost arbitrations.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_rw,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_busy,
  output logic          arb_owner
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu_cnt,
  output logic [15:0]   stat_ldr_cnt
`endif
);

  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_rw_q, mem_rw_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            ldr_ack_q, ldr_ack_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic            grant_ldr;

  // Next-state and next-output logic; every output is computed here one cycle ahead and registered.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_en_d    = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    // Loader wins when alone, or when it has already lost STARVE_MAX times in a row.
    grant_ldr   = ldr_req && (!cpu_req || (starve_q == SW'(STARVE_MAX)));
    case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          owner_d     = grant_ldr;
          mem_rw_d    = grant_ldr ? ldr_rw    : cpu_rw;
          mem_addr_d  = grant_ldr ? ldr_addr  : cpu_addr;
          mem_wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
          mem_en_d    = 1'b1;
          busy_d      = 1'b1;
          state_d     = ISSUE;
          if (grant_ldr) begin
            starve_d = '0;
          end else if (ldr_req && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      ISSUE: begin
        lat_d   = CW'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == CW'(1)) begin
          // Memory data is valid this cycle; writes leave the owner's rdata untouched.
          if (!mem_rw_q) begin
            if (owner_q) ldr_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          ldr_ack_d = owner_q;
          cpu_ack_d = !owner_q;
          state_d   = ACK;
        end else begin
          lat_d = lat_q - CW'(1);
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access in flight without an ack.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign arb_busy  = busy_q;
  assign arb_owner = owner_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_cpu_q, stat_ldr_q;

  // Saturating count of completed accesses per port, stepping together with the ack it counts.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stat_cpu_q <= '0;
      stat_ldr_q <= '0;
    end else begin
      if (cpu_ack_d && (stat_cpu_q != 16'hFFFF)) stat_cpu_q <= stat_cpu_q + 16'd1;
      if (ldr_ack_d && (stat_ldr_q != 16'hFFFF)) stat_ldr_q <= stat_ldr_q + 16'd1;
    end
  end

  assign stat_cpu_cnt = stat_cpu_q;
  assign stat_ldr_cnt = stat_ldr_q;
`endif

endmodule
